// File: rtl/ssd_write_scheduler.sv
// Two-requester scheduler: saturates a 14-bit value, converts it to 4 BCD digits
// by serial double-dabble and writes them to a 7-seg display port, thousands first.
// Define SSD_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (req0 wins).
module ssd_write_scheduler #(
  parameter int WR_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [13:0] val0,
  output logic        ack0,
  input  logic        req1,
  input  logic [13:0] val1,
  output logic        ack1,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  num,
  output logic [1:0]  sel,
  output logic        wr
);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  localparam logic [3:0] GAP = 4'(WR_GAP);

  state_t      state, state_n;
  logic [29:0] sh, sh_n, step;      // {bcd[15:0], bin[13:0]}
  logic [3:0]  cnt, cnt_n;          // conversion step / gap counter
  logic [1:0]  dig, dig_n;
  logic        gnt, gnt_n;          // 1 = requester 1 owns the transfer
  logic [3:0]  num_n;
  logic [1:0]  sel_n;
  logic        wr_n, ack0_n, ack1_n, busy_n, ovf_n;
  logic        pick1;
  logic [13:0] val_sel, val_sat;

`ifdef SSD_SCHED_ROUND_ROBIN_EN
  logic last;  // requester granted most recently; reset to 1 so req0 wins first
  assign pick1 = req1 & (~req0 | ~last);
  always_ff @(posedge clk) begin
    if (reset)                                last <= 1'b1;
    else if (state == IDLE && (req0 | req1))  last <= pick1;
  end
`else
  assign pick1 = req1 & ~req0;
`endif

  assign val_sel = pick1 ? val1 : val0;
  assign val_sat = (val_sel > 14'd9999) ? 14'd9999 : val_sel;

  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++)
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [3:0] digit(input logic [29:0] s, input logic [1:0] k);
    case (k)
      2'd0:    digit = s[29:26];
      2'd1:    digit = s[25:22];
      2'd2:    digit = s[21:18];
      default: digit = s[17:14];
    endcase
  endfunction

  assign step = dd_step(sh);

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    dig_n   = dig;
    gnt_n   = gnt;
    num_n   = num;
    sel_n   = sel;
    wr_n    = 1'b0;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    busy_n  = busy;
    ovf_n   = ovf;
    case (state)
      IDLE: if (req0 | req1) begin
        state_n = CONV;
        gnt_n   = pick1;
        sh_n    = {16'd0, val_sat};
        ovf_n   = (val_sel > 14'd9999);
        cnt_n   = 4'd0;
        busy_n  = 1'b1;
      end
      CONV: begin
        sh_n  = step;
        cnt_n = cnt + 4'd1;
        // last step: launch the thousands digit straight from the final shift
        if (cnt == 4'd13) begin
          state_n = WRITE;
          wr_n    = 1'b1;
          sel_n   = 2'd0;
          num_n   = step[29:26];
          dig_n   = 2'd0;
          cnt_n   = 4'd0;
        end
      end
      WRITE: begin
        if (cnt == GAP) begin
          if (dig == 2'd3) begin
            state_n = DONE;
            ack0_n  = ~gnt;
            ack1_n  = gnt;
          end else begin
            dig_n = dig + 2'd1;
            wr_n  = 1'b1;
            sel_n = dig + 2'd1;
            num_n = digit(sh, dig + 2'd1);
            cnt_n = 4'd0;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      dig   <= '0;
      gnt   <= 1'b0;
      num   <= '0;
      sel   <= '0;
      wr    <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      dig   <= dig_n;
      gnt   <= gnt_n;
      num   <= num_n;
      sel   <= sel_n;
      wr    <= wr_n;
      ack0  <= ack0_n;
      ack1  <= ack1_n;
      busy  <= busy_n;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_ssd_write_scheduler.sv
// Scoreboard bench for ssd_write_scheduler: stimulus pushes expected digit writes and
// acks (with cycle stamps); a negedge monitor pops and compares as the DUT emits them.
module tb_ssd_write_scheduler;
  localparam int G   = 1;
  localparam int LEN = 15 + 4 * (1 + G);   // grant cycle T to DONE cycle

  logic        clk = 1'b0, reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [13:0] val0 = '0, val1 = '0;
  logic        ack0, ack1, busy, ovf, wr;
  logic [3:0]  num;
  logic [1:0]  sel;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;

  typedef struct {
    bit         is_ack;
    int         cyc;
    logic [1:0] sel;
    logic [3:0] num;
    logic [1:0] acks;
    logic       ovf;
  } ev_t;
  ev_t q[$];

  ssd_write_scheduler #(.WR_GAP(G)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .val0(val0), .ack0(ack0),
    .req1(req1), .val1(val1), .ack1(ack1),
    .busy(busy), .ovf(ovf), .num(num), .sel(sel), .wr(wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_xfer(input bit id, input int t, input logic [15:0] bcd, input logic ov);
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      e = '{is_ack: 1'b0, cyc: t + 15 + k * (1 + G), sel: 2'(k),
            num: bcd[15-4*k -: 4], acks: 2'b00, ovf: 1'b0};
      q.push_back(e);
    end
    e = '{is_ack: 1'b1, cyc: t + LEN, sel: 2'd0, num: 4'd0,
          acks: id ? 2'b10 : 2'b01, ovf: ov};
    q.push_back(e);
  endtask

  // Caller is at a negedge; returns at the negedge of the first idle cycle after DONE.
  task automatic xfer(input bit id, input logic [13:0] v, input logic [15:0] bcd, input logic ov);
    int t;
    if (id) begin req1 = 1'b1; val1 = v; end
    else    begin req0 = 1'b1; val0 = v; end
    t = cyc;
    push_xfer(id, t, bcd, ov);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    val0 = ~v;  val1 = ~v;          // post-grant value changes must not matter
    check("busy_at_T+1", busy, 1);
    check("ovf_at_T+1", ovf, ov);
    repeat (LEN - 1) @(negedge clk);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_num"}, num, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_acks"}, {ack1, ack0}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  // Monitor: every write strobe or ack must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (wr) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got sel=%0d num=%0d at cycle %0d, expected no write", sel, num, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_ack || e.cyc != cyc || e.sel != sel || e.num != num) begin
          n_fail++;
          $display("FAIL wr_event: got cyc=%0d sel=%0d num=%0d, expected is_ack=%0d cyc=%0d sel=%0d num=%0d",
                   cyc, sel, num, e.is_ack, e.cyc, e.sel, e.num);
        end
      end
    end
    if (ack0 | ack1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got acks=%b at cycle %0d, expected none", {ack1, ack0}, cyc);
      end else begin
        e = q.pop_front();
        if (!e.is_ack || e.cyc != cyc || e.acks != {ack1, ack0} || e.ovf != ovf) begin
          n_fail++;
          $display("FAIL ack_event: got cyc=%0d acks=%b ovf=%0d, expected is_ack=%0d cyc=%0d acks=%b ovf=%0d",
                   cyc, {ack1, ack0}, ovf, e.is_ack, e.cyc, e.acks, e.ovf);
        end
      end
    end
  end

  initial begin
    int t;
    @(negedge clk);
    do_reset();
    check_reset_outs("reset");

    xfer(1'b0, 14'd1234,  16'h1234, 1'b0);
    xfer(1'b1, 14'd12000, 16'h9999, 1'b1);
    xfer(1'b0, 14'd5,     16'h0005, 1'b0);
    xfer(1'b0, 14'd0,     16'h0000, 1'b0);
    xfer(1'b0, 14'd10000, 16'h9999, 1'b1);
    xfer(1'b1, 14'd16383, 16'h9999, 1'b1);
    xfer(1'b1, 14'd8070,  16'h8070, 1'b0);

    // req held past grant, then dropped with value cleared mid-conversion
    req0 = 1'b1; val0 = 14'd9999; t = cyc;
    push_xfer(1'b0, t, 16'h9999, 1'b0);
    repeat (3) @(negedge clk);
    req0 = 1'b0; val0 = 14'd0;
    repeat (LEN - 3 + 1) @(negedge clk);
    check("busy_idle_after_drop", busy, 0);

    // simultaneous requests held across four transfers
    do_reset();
    req0 = 1'b1; req1 = 1'b1; val0 = 14'd1111; val1 = 14'd2222; t = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef SSD_SCHED_ROUND_ROBIN_EN
      if (k % 2 == 1) push_xfer(1'b1, t + k * (LEN + 1), 16'h2222, 1'b0);
      else            push_xfer(1'b0, t + k * (LEN + 1), 16'h1111, 1'b0);
`else
      push_xfer(1'b0, t + k * (LEN + 1), 16'h1111, 1'b0);
`endif
    end
    repeat (3 * (LEN + 1) + 1) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (LEN) @(negedge clk);
    check("busy_after_contention", busy, 0);

    // reset during the first digit write aborts the transfer
    req0 = 1'b1; val0 = 14'd4321; t = cyc;
    q.push_back('{is_ack: 1'b0, cyc: t + 15, sel: 2'd0, num: 4'd4, acks: 2'b00, ovf: 1'b0});
    @(negedge clk);
    req0 = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outs("abort");
    repeat (30) @(negedge clk);
    check("abort_busy_stays_low", busy, 0);

    xfer(1'b0, 14'd607, 16'h0607, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ssd_write_scheduler.md
SSD_WRITE_SCHEDULER -- requirements
Module: ssd_write_scheduler

Interface
REQ-001 Parameter: WR_GAP, default 1, number of idle cycles (wr low) after each digit write; legal 0..15.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 (CPU store path) display-update request, level.
REQ-005 val0  input  14  requester 0 binary value to display.
REQ-006 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-007 req1  input  1  requester 1 (debug path) display-update request, level.
REQ-008 val1  input  14  requester 1 binary value to display.
REQ-009 ack1  output  1  one-cycle completion pulse to requester 1.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 ovf  output  1  latest accepted value exceeded 9999 and was saturated.
REQ-012 num  output  4  BCD digit to display write port.
REQ-013 sel  output  2  digit position to display write port (0 = leftmost/thousands, 3 = rightmost/units).
REQ-014 wr  output  1  display write strobe, one cycle per digit.

Function
REQ-015 FSM states SHALL be IDLE, CONV, WRITE, DONE; all outputs registered.
REQ-016 IDLE: when req0 or req1 is high at cycle T, grant one requester, latch its value, go to CONV at T+1; no req -> stay IDLE.
REQ-017 Latched value SHALL be min(val, 9999); ovf SHALL be set to (val > 9999) at grant and held until next grant.
REQ-018 CONV: sequential double-dabble, one shift/add-3 step per cycle, exactly 14 cycles (T+1..T+14), producing 4 BCD digits.
REQ-019 WRITE: digit k (k=0..3, thousands first) written with wr=1, sel=k, num=digit k at cycle T+15+k*(1+WR_GAP); wr=0 on all other cycles; WR_GAP idle cycles follow every write including the last.
REQ-020 DONE at cycle T+15+4*(1+WR_GAP): ack of granted requester high for exactly that one cycle, other ack low; next state IDLE.
REQ-021 num and sel SHALL hold their last written values while wr is low.
REQ-022 busy SHALL be high from T+1 through the DONE cycle inclusive; low in IDLE.
REQ-023 Requests are not sampled outside IDLE; earliest next grant is the cycle after DONE.
REQ-024 Requester deasserting req before its ack SHALL NOT abort the transfer; ack still pulses.
REQ-025 val changes after grant SHALL NOT affect the displayed digits.
REQ-026 Value 0 SHALL write digits 0,0,0,0 (no blanking of leading zeros).

Reset
REQ-027 On reset: state IDLE, num=0, sel=0, wr=0, ack0=0, ack1=0, busy=0, ovf=0, arbitration pointer favours requester 0.
REQ-028 Reset mid-CONV or mid-WRITE SHALL abort immediately: no further wr, no ack; digits already written to the display remain.

Configuration
REQ-029 Macro SSD_SCHED_ROUND_ROBIN_EN defined: round-robin arbitration; on simultaneous requests grant the requester not granted last (requester 0 after reset).
REQ-030 Macro undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer state.

Verification
REQ-031 WR_GAP=1, req0 at T with val0=1234 -> wr at T+15/17/19/21 with (sel,num)=(0,1),(1,2),(2,3),(3,4); ack0 at T+23; ovf=0.
REQ-032 val1=12000 via req1 -> digits 9,9,9,9 written, ovf=1 from T+1; subsequent val0=5 -> digits 0,0,0,5, ovf=0.
REQ-033 req0 and req1 held high continuously, round-robin enabled -> grants alternate 0,1,0,1; macro undefined -> all grants to 0.
REQ-034 reset asserted at first write cycle of a transfer -> wr low from next cycle, no ack, busy=0, all outputs at reset values; new req0 then completes normally.
REQ-035 WR_GAP=0, val0=9999, req0 dropped at T+3 and val0 changed to 0 -> wr at T+15..T+18 with num=9 each, ack0 at T+19.
